// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready buffer presenting a fetched instruction and its PC to decode.
module fetch_out_buf
    import mips_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // A load in the same cycle as a consume wins: the new entry replaces the old one.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding word fetch at a time and
// hands returned instructions to decode; EX redirects flush and reload the PC.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready,
    output logic               misalign_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              misalign_err_q, misalign_err_d;

    logic buf_free;
    logic req_fire;
    logic rsp_load;

    // Issuing only into a free buffer guarantees every response lands without stalling.
    assign buf_free       = !if_valid || if_ready;
    assign imem_req_valid = (state_q == ISSUE) && buf_free;
    assign imem_req_addr  = (state_q == IDLE) ? '0 : word_align(pc_q);
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        rsp_load       = 1'b0;
        misalign_err_d = redirect_valid && (redirect_target[1:0] != 2'b00);

        case (state_q)
            IDLE: state_d = ISSUE;
            ISSUE: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    state_d  = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ISSUE;
                    if (!redirect_valid) begin
                        rsp_load = 1'b1;
                        pc_d     = req_pc_q + PC_STEP;
                    end
                end else if (redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) pc_d = word_align(redirect_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err = misalign_err_q;

    fetch_out_buf u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (rsp_load),
        .consume    (if_valid && if_ready),
        .flush      (redirect_valid),
        .load_pc    (req_pc_q),
        .load_instr (imem_rsp_data),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share inputs; a simple memory model answers one cycle after each accept.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        if_ready = 1'b1;

    logic        rv0, iv0, me0, rv1, iv1, me1;
    logic [31:0] ra0, ip0, ii0, ra1, ip1, ii1;

    bit mem_auto = 1'b1;
    bit sel = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut0 (
        .clk(clk), .reset(reset),
        .imem_req_valid(rv0), .imem_req_addr(ra0), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(iv0), .if_pc(ip0), .if_instr(ii0), .if_ready(if_ready),
        .misalign_err(me0)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut1 (
        .clk(clk), .reset(reset),
        .imem_req_valid(rv1), .imem_req_addr(ra1), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(iv1), .if_pc(ip1), .if_instr(ii1), .if_ready(if_ready),
        .misalign_err(me1)
    );

    // Advance one clock; in auto mode the memory answers the request accepted on this edge.
    task automatic cycle();
        bit fire;
        logic [31:0] a;
        #1;
        fire = sel ? ((rv1 && imem_req_ready) === 1'b1) : ((rv0 && imem_req_ready) === 1'b1);
        a = sel ? ra1 : ra0;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rsp_valid = fire;
            imem_rsp_data  = a ^ 32'hC0DE_0000;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_checks++; if (rv0 !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", rv0); else n_pass++;
        n_checks++; if (ra0 !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", ra0); else n_pass++;
        n_checks++; if (iv0 !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", iv0); else n_pass++;
        n_checks++; if (ip0 !== 32'h0) $display("FAIL rst_if_pc: got %h want 0", ip0); else n_pass++;
        n_checks++; if (ii0 !== 32'h0) $display("FAIL rst_if_instr: got %h want 0", ii0); else n_pass++;
        n_checks++; if (me0 !== 1'b0) $display("FAIL rst_misalign: got %b want 0", me0); else n_pass++;
        n_checks++; if (iv1 !== 1'b0) $display("FAIL rst_if_valid1: got %b want 0", iv1); else n_pass++;
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        cycle();
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h0) $display("FAIL seq_req0: got v=%b a=%h want v=1 a=0", rv0, ra0); else n_pass++;
        n_checks++; if (iv0 !== 1'b0) $display("FAIL seq_ifv_c1: got %b want 0", iv0); else n_pass++;
        cycle();
        n_checks++; if (rv0 !== 1'b0 || iv0 !== 1'b0) $display("FAIL seq_wait: got rv=%b iv=%b want 0 0", rv0, iv0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h0 || ii0 !== 32'hC0DE_0000)
            $display("FAIL seq_out0: got v=%b pc=%h i=%h want 1 0 c0de0000", iv0, ip0, ii0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h4) $display("FAIL seq_req4: got v=%b a=%h want 1 4", rv0, ra0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b0) $display("FAIL seq_gap1: got %b want 0", iv0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h4 || ii0 !== 32'hC0DE_0004)
            $display("FAIL seq_out4: got v=%b pc=%h i=%h want 1 4 c0de0004", iv0, ip0, ii0); else n_pass++;
        n_checks++; if (ra0 !== 32'h8) $display("FAIL seq_req8: got %h want 8", ra0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b0) $display("FAIL seq_gap2: got %b want 0", iv0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h8 || ii0 !== 32'hC0DE_0008)
            $display("FAIL seq_out8: got v=%b pc=%h i=%h want 1 8 c0de0008", iv0, ip0, ii0); else n_pass++;
    endtask

    task automatic test_stall();
        if_ready = 1'b0;
        #1;
        n_checks++; if (rv0 !== 1'b0) $display("FAIL stall_req_now: got %b want 0", rv0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++; if (rv0 !== 1'b0 || iv0 !== 1'b1 || ip0 !== 32'h8 || ii0 !== 32'hC0DE_0008)
                $display("FAIL stall_hold%0d: got rv=%b iv=%b pc=%h i=%h want 0 1 8 c0de0008", i, rv0, iv0, ip0, ii0);
            else n_pass++;
        end
        if_ready = 1'b1;
        #1;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'hC) $display("FAIL stall_release: got v=%b a=%h want 1 c", rv0, ra0); else n_pass++;
        mem_auto = 1'b0;
        cycle();
        n_checks++; if (iv0 !== 1'b0 || rv0 !== 1'b0) $display("FAIL stall_consumed: got iv=%b rv=%b want 0 0", iv0, rv0); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1; redirect_target = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        n_checks++; if (iv0 !== 1'b0 || rv0 !== 1'b0 || me0 !== 1'b0)
            $display("FAIL rw_drain: got iv=%b rv=%b me=%b want 0 0 0", iv0, rv0, me0); else n_pass++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC0DE_000C;
        cycle();
        imem_rsp_valid = 1'b0;
        n_checks++; if (iv0 !== 1'b0) $display("FAIL rw_dropped: got if_valid %b want 0", iv0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h100) $display("FAIL rw_req100: got v=%b a=%h want 1 100", rv0, ra0); else n_pass++;
        mem_auto = 1'b1;
        cycle();
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h100 || ii0 !== 32'hC0DE_0100)
            $display("FAIL rw_out100: got v=%b pc=%h i=%h want 1 100 c0de0100", iv0, ip0, ii0); else n_pass++;
    endtask

    task automatic test_redirect_issue_flush();
        if_ready = 1'b0; imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h10;
        cycle();
        redirect_valid = 1'b0; if_ready = 1'b1;
        #1;
        n_checks++; if (iv0 !== 1'b0) $display("FAIL ri_flush: got if_valid %b want 0", iv0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h10) $display("FAIL ri_req10: got v=%b a=%h want 1 10", rv0, ra0); else n_pass++;
        imem_req_ready = 1'b1;
    endtask

    task automatic test_redirect_with_rsp();
        cycle();
        n_checks++; if (imem_rsp_valid !== 1'b1 || rv0 !== 1'b0) $display("FAIL rr_setup: got rsp=%b rv=%b want 1 0", imem_rsp_valid, rv0); else n_pass++;
        redirect_valid = 1'b1; redirect_target = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        n_checks++; if (iv0 !== 1'b0) $display("FAIL rr_no10: got if_valid %b pc %h want 0", iv0, ip0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h200) $display("FAIL rr_req200: got v=%b a=%h want 1 200", rv0, ra0); else n_pass++;
        cycle();
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h200 || ii0 !== 32'hC0DE_0200)
            $display("FAIL rr_out200: got v=%b pc=%h i=%h want 1 200 c0de0200", iv0, ip0, ii0); else n_pass++;
    endtask

    task automatic test_misalign();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        cycle();
        redirect_valid = 1'b0;
        n_checks++; if (me0 !== 1'b1) $display("FAIL mis_pulse: got %b want 1", me0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h100) $display("FAIL mis_addr: got v=%b a=%h want 1 100", rv0, ra0); else n_pass++;
        cycle();
        n_checks++; if (me0 !== 1'b0) $display("FAIL mis_one_cycle: got %b want 0", me0); else n_pass++;
        imem_req_ready = 1'b1;
    endtask

    task automatic test_redirect_on_accept();
        redirect_valid = 1'b1; redirect_target = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        n_checks++; if (rv0 !== 1'b0 || iv0 !== 1'b0) $display("FAIL ra_drain: got rv=%b iv=%b want 0 0", rv0, iv0); else n_pass++;
        cycle();
        n_checks++; if (iv0 !== 1'b0) $display("FAIL ra_dropped: got if_valid %b want 0", iv0); else n_pass++;
        n_checks++; if (rv0 !== 1'b1 || ra0 !== 32'h300) $display("FAIL ra_req300: got v=%b a=%h want 1 300", rv0, ra0); else n_pass++;
        cycle();
        cycle();
        n_checks++; if (iv0 !== 1'b1 || ip0 !== 32'h300 || ii0 !== 32'hC0DE_0300)
            $display("FAIL ra_out300: got v=%b pc=%h i=%h want 1 300 c0de0300", iv0, ip0, ii0); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        sel = 1'b1;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        n_checks++; if (rv1 !== 1'b1 || ra1 !== 32'hFFFF_FFFC) $display("FAIL wr_req_top: got v=%b a=%h want 1 fffffffc", rv1, ra1); else n_pass++;
        cycle();
        cycle();
        n_checks++; if (iv1 !== 1'b1 || ip1 !== 32'hFFFF_FFFC || ii1 !== 32'h3F21_FFFC)
            $display("FAIL wr_out_top: got v=%b pc=%h i=%h want 1 fffffffc 3f21fffc", iv1, ip1, ii1); else n_pass++;
        n_checks++; if (rv1 !== 1'b1 || ra1 !== 32'h0) $display("FAIL wr_wrap: got v=%b a=%h want 1 0", rv1, ra1); else n_pass++;
        mem_auto = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        n_checks++; if (iv1 !== 1'b0 || rv1 !== 1'b0 || ra1 !== 32'h0)
            $display("FAIL wr_reset: got iv=%b rv=%b a=%h want 0 0 0", iv1, rv1, ra1); else n_pass++;
        reset = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        cycle();
        n_checks++; if (iv1 !== 1'b0 || ra1 !== 32'hFFFF_FFFC)
            $display("FAIL wr_stale1: got iv=%b a=%h want 0 fffffffc", iv1, ra1); else n_pass++;
        cycle();
        n_checks++; if (iv1 !== 1'b0) $display("FAIL wr_stale2: got if_valid %b want 0", iv1); else n_pass++;
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; mem_auto = 1'b1;
        cycle();
        cycle();
        n_checks++; if (iv1 !== 1'b1 || ip1 !== 32'hFFFF_FFFC || ii1 !== 32'h3F21_FFFC)
            $display("FAIL wr_restart: got v=%b pc=%h i=%h want 1 fffffffc 3f21fffc", iv1, ip1, ii1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_issue_flush();
        test_redirect_with_rsp();
        test_misalign();
        test_redirect_on_accept();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
